// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: round-robin sequencer sharing one single-port sync RAM; define RAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority
module ram_sp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_rdata,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic                      ram_oe,
  output logic [AWIDTH-1:0]         ram_addr,
  inout  wire  [DWIDTH-1:0]         ram_data
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RSP} state_t;
  state_t state;
  logic [IW-1:0] owner, win;
  logic [DWIDTH-1:0] wdata_q;
  int j;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic [IW-1:0] last_gnt;
`endif
  // Scan from the lowest priority down so the last hit is the winner
  always_comb begin
    win = '0;
    j = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      j = k - 1;
`else
      j = (int'(last_gnt) + k) % NUM_REQ;
`endif
      if (req_valid[j]) win = IW'(j);
    end
  end
  assign req_ready = (state == IDLE && |req_valid) ? NUM_REQ'(1) << win : '0;
  assign ram_data = (state == WR) ? wdata_q : 'z;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      wdata_q <= '0;
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      ram_oe <= 1'b0;
      ram_addr <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_gnt <= IW'(NUM_REQ - 1);
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (|req_valid) begin
          owner <= win;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_gnt <= win;
`endif
          wdata_q <= req_wdata[int'(win)*DWIDTH +: DWIDTH];
          ram_addr <= req_addr[int'(win)*AWIDTH +: AWIDTH];
          ram_cs <= 1'b1;
          ram_we <= req_we[win];
          ram_oe <= !req_we[win];
          state <= req_we[win] ? WR : RD_ADDR;
        end
        WR: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          rsp_valid <= NUM_REQ'(1) << owner;
          state <= RSP;
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          ram_cs <= 1'b0;
          ram_oe <= 1'b0;
          rsp_rdata <= ram_data;
          rsp_valid <= NUM_REQ'(1) << owner;
          state <= RSP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
